// File: rtl/adxl_burst_sampler_if.sv
// Sample stream and SPI bus bundle for adxl_burst_sampler.
//   sample_valid/sample_ready/sample_data : head-of-FIFO handshake, one axis per 16 bits
//   SPI_CSN/SPI_CLK/SPI_SDI               : SPI master outputs (mode 3)
//   SPI_SDO                               : SPI slave data into the sampler
// master = sampler side, slave = consumer / accelerometer side.
interface adxl_burst_sampler_if #(
  parameter int unsigned N_AXES = 3
) ();
  logic                    sample_valid;
  logic                    sample_ready;
  logic [16*N_AXES-1:0]    sample_data;
  logic                    SPI_CSN;
  logic                    SPI_CLK;
  logic                    SPI_SDI;
  logic                    SPI_SDO;

  modport master (
    output sample_valid, sample_data, SPI_CSN, SPI_CLK, SPI_SDI,
    input  sample_ready, SPI_SDO
  );

  modport slave (
    input  sample_valid, sample_data, SPI_CSN, SPI_CLK, SPI_SDI,
    output sample_ready, SPI_SDO
  );
endinterface

// File: rtl/adxl_burst_sampler.sv
// SPI sampler for ADXL345-class accelerometers.
// After reset it replays INIT_TABLE as single-byte register writes, then on
// every sample tick reads N_AXES axes in one multi-byte burst (one CSN window)
// and queues the result in a DEPTH-entry FIFO.
// Ports:
//   n_rst        : asynchronous active-low reset
//   spi_clk      : clock, everything on the rising edge
//   freeze       : discard completed bursts instead of queueing them
//   bus          : sample handshake + SPI pins (master modport)
//   fifo_level   : FIFO occupancy 0..DEPTH
//   overflow_cnt : samples dropped on a full FIFO, saturating at 255
//   init_done    : init table fully written
module adxl_burst_sampler #(
  parameter int unsigned          SAMPLE_DIV = 200,
  parameter int unsigned          N_AXES     = 3,
  parameter logic [5:0]           START_ADDR = 6'h32,
  parameter int unsigned          INIT_LEN   = 11,
  parameter logic [16*INIT_LEN-1:0] INIT_TABLE =
    176'h2D08_2A00_2000_1F00_1E00_2F00_2E00_3800_2C0A_3108_2D00,
  parameter int unsigned          DEPTH      = 4
) (
  input  logic                      n_rst,
  input  logic                      spi_clk,
  input  logic                      freeze,
  adxl_burst_sampler_if.master      bus,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [7:0]                overflow_cnt,
  output logic                      init_done
);
  localparam int unsigned NB   = 2 * N_AXES;
  localparam int unsigned RXW  = 8 * NB;
  localparam int unsigned TXW  = 8 + RXW;
  localparam int unsigned BCW  = $clog2(TXW);
  localparam int unsigned TCW  = $clog2(SAMPLE_DIV);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned LW   = PW + 1;
  localparam int unsigned IDXW = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
  localparam logic        MB   = (NB > 1);

  // bit 2 set exactly while chip select is asserted, so SPI_CSN is one flop
  localparam logic [2:0] ST_INIT_LOAD = 3'b000;
  localparam logic [2:0] ST_WAIT      = 3'b001;
  localparam logic [2:0] ST_GAP       = 3'b010;
  localparam logic [2:0] ST_CS_SETUP  = 3'b100;
  localparam logic [2:0] ST_SHIFT     = 3'b101;
  localparam logic [2:0] ST_CS_HOLD   = 3'b110;

  logic [2:0]       state;
  logic             phase;      // 0 = SPI_CLK low half of a bit, 1 = high half
  logic [BCW-1:0]   bit_cnt;
  logic             gap_cnt;
  logic [IDXW-1:0]  init_idx;
  logic [TXW-1:0]   tx_sr;
  logic [RXW-1:0]   rx_sr;
  logic [TCW-1:0]   timer;
  logic             pending;
  logic             tick;
  logic [13:0]      init_entry;
  logic [BCW-1:0]   last_bit;
  logic [RXW-1:0]   sample_word;

  logic [RXW-1:0]   mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             full;

  always_comb begin
    init_entry = INIT_TABLE[{init_idx, 4'b0000} +: 14];
    last_bit   = init_done ? BCW'(TXW - 1) : BCW'(15);
    tick       = init_done && (timer == TCW'(SAMPLE_DIV - 1));
  end

  // First received data byte ends up at the top of rx_sr; byte j goes to bits 8j+:8.
  always_comb begin
    sample_word = '0;
    for (int unsigned j = 0; j < NB; j++)
      sample_word[8*j +: 8] = rx_sr[RXW-1-8*j -: 8];
  end

  always_ff @(posedge spi_clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_INIT_LOAD;
      phase     <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= 1'b0;
      init_idx  <= '0;
      tx_sr     <= '1;
      rx_sr     <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT_LOAD: begin
          tx_sr <= {2'b00, init_entry, {(TXW-16){1'b1}}};
          state <= ST_CS_SETUP;
        end
        ST_CS_SETUP: begin
          phase   <= 1'b0;
          bit_cnt <= '0;
          state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          phase <= ~phase;
          if (!phase) begin
            rx_sr <= {rx_sr[RXW-2:0], bus.SPI_SDO};
          end else begin
            tx_sr   <= {tx_sr[TXW-2:0], 1'b1};
            bit_cnt <= bit_cnt + BCW'(1);
            if (bit_cnt == last_bit) state <= ST_CS_HOLD;
          end
        end
        ST_CS_HOLD: begin
          gap_cnt <= 1'b0;
          state   <= ST_GAP;
        end
        ST_GAP: begin
          gap_cnt <= 1'b1;
          if (gap_cnt) begin
            if (init_done) begin
              state <= ST_WAIT;
            end else if (init_idx == IDXW'(INIT_LEN - 1)) begin
              init_done <= 1'b1;
              state     <= ST_WAIT;
            end else begin
              init_idx <= init_idx + IDXW'(1);
              state    <= ST_INIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (tick || pending) begin
            tx_sr <= {1'b1, MB, START_ADDR, {(TXW-8){1'b1}}};
            state <= ST_CS_SETUP;
          end
        end
        default: state <= ST_INIT_LOAD;
      endcase
    end
  end

  // Sample timer free-runs once init is complete; one tick may wait for WAIT.
  always_ff @(posedge spi_clk or negedge n_rst) begin
    if (!n_rst) begin
      timer   <= '0;
      pending <= 1'b0;
    end else begin
      if (!init_done || tick) timer <= '0;
      else                    timer <= timer + TCW'(1);
      if (state == ST_WAIT) begin
        if (tick || pending) pending <= 1'b0;
      end else if (tick) begin
        pending <= 1'b1;
      end
    end
  end

  assign bus.SPI_CSN = ~state[2];
  assign bus.SPI_CLK = ~((state == ST_SHIFT) && !phase);
  assign bus.SPI_SDI = (state == ST_SHIFT) ? tx_sr[TXW-1] : 1'b1;

  // FIFO: a full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    full     = (fifo_level == LW'(DEPTH));
    pop      = bus.sample_valid && bus.sample_ready;
    push_req = (state == ST_CS_HOLD) && init_done && !freeze;
    push_ok  = push_req && (!full || pop);
  end

  always_ff @(posedge spi_clk) begin
    if (push_ok) mem[wr_ptr] <= sample_word;
  end

  always_ff @(posedge spi_clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      overflow_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (push_req && full && !pop && overflow_cnt != 8'hFF)
        overflow_cnt <= overflow_cnt + 8'd1;
    end
  end

  assign bus.sample_valid = (fifo_level != '0);
  assign bus.sample_data  = bus.sample_valid ? mem[rd_ptr] : '0;

endmodule
